// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions.
//   mem_state_t : memory-stage FSM states
//   DW_DEFAULT  : default data/address width
//   RW_DEFAULT  : default destination register index width
//   mem_wb_t    : MEM/WB pipeline register contents, shared with writeback
package cpu_pkg;

  localparam int DW_DEFAULT = 32;
  localparam int RW_DEFAULT = 4;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic [DW_DEFAULT-1:0] result;
    logic                  wreg;
    logic [RW_DEFAULT-1:0] rd;
  } mem_wb_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register.
//   clk, rst : clock, async active-high reset (clears to all-zero)
//   bubble   : load an all-zero entry (wreg=0) instead of d
//   d        : next MEM/WB contents
//   q        : registered MEM/WB contents
module mem_wb_reg
  import cpu_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    bubble,
  input  mem_wb_t d,
  output mem_wb_t q
);

  // Bubbles are all-zero rather than "wreg cleared, rest kept" so that
  // result/rd stay deterministic when writeback is disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         q <= '0;
    else if (bubble) q <= '0;
    else             q <= d;
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage.
// Takes the EX/MEM register outputs, performs loads/stores over a req/ack
// data-memory handshake, stalls upstream while memory is busy, aborts a
// request after TIMEOUT wait cycles, and drives the MEM/WB register.
//   clk, rst                : clock, async active-high reset
//   ex_alu_r                : ALU result / memory address
//   ex_wr_data              : store data
//   ex_wmem, ex_rmem        : store / load request (store wins if both)
//   ex_wreg, ex_rd          : writeback enable / destination
//   dm_req, dm_we           : memory request, 1 = write
//   dm_addr, dm_wdata       : memory address / write data
//   dm_ack, dm_rdata        : memory completion, read data (same cycle)
//   stall                   : freeze EX/MEM and upstream
//   wb_result, wb_wreg, wb_rd : MEM/WB register outputs
//   mem_err                 : one-cycle pulse on request timeout
// DW/RW overrides must match the widths of cpu_pkg::mem_wb_t.
module mem_stage
  import cpu_pkg::*;
#(
  parameter int DW      = DW_DEFAULT,
  parameter int RW      = RW_DEFAULT,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] ex_alu_r,
  input  logic [DW-1:0] ex_wr_data,
  input  logic          ex_wmem,
  input  logic          ex_rmem,
  input  logic          ex_wreg,
  input  logic [RW-1:0] ex_rd,
  output logic          dm_req,
  output logic          dm_we,
  output logic [DW-1:0] dm_addr,
  output logic [DW-1:0] dm_wdata,
  input  logic          dm_ack,
  input  logic [DW-1:0] dm_rdata,
  output logic          stall,
  output logic [DW-1:0] wb_result,
  output logic          wb_wreg,
  output logic [RW-1:0] wb_rd,
  output logic          mem_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  mem_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  // Holding register: the in-flight op, captured at issue.
  logic          h_we;
  logic          h_wreg;
  logic [DW-1:0] h_addr;
  logic [DW-1:0] h_wdata;
  logic [RW-1:0] h_rd;

  logic    memop, in_wait, timeout_hit, bubble;
  mem_wb_t wb_d, wb_q;

  assign memop       = ex_wmem | ex_rmem;
  assign in_wait     = (state == WAIT);
  assign timeout_hit = in_wait & ~dm_ack & (cnt == CW'(TIMEOUT - 1));

  // Gating with rst drops the request the instant reset asserts, even if
  // a memop is still presented on the ex_* inputs.
  assign dm_req   = ~rst & (in_wait | memop);
  assign dm_we    = in_wait ? h_we    : ex_wmem;
  assign dm_addr  = in_wait ? h_addr  : ex_alu_r;
  assign dm_wdata = in_wait ? h_wdata : ex_wr_data;

  // The aborting cycle does not stall, so upstream moves past the
  // faulting instruction on the same edge it is dropped.
  assign stall = ~rst & ((~in_wait & memop & ~dm_ack) |
                         (in_wait & ~dm_ack & ~timeout_hit));

  // Next state / counter
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (memop && !dm_ack) begin
          state_nxt = WAIT;
          cnt_nxt   = '0;
        end
      end
      WAIT: begin
        if (dm_ack || timeout_hit) state_nxt = IDLE;
        else                       cnt_nxt   = cnt + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // MEM/WB next value: completion loads the result, any unfinished or
  // aborted memory cycle loads a bubble.
  always_comb begin
    bubble      = 1'b0;
    wb_d        = '0;
    wb_d.result = ex_alu_r;
    wb_d.wreg   = ex_wreg;
    wb_d.rd     = ex_rd;
    if (in_wait) begin
      if (dm_ack) begin
        wb_d.result = h_we ? h_addr : dm_rdata;
        wb_d.wreg   = h_wreg;
        wb_d.rd     = h_rd;
      end else begin
        bubble = 1'b1;
      end
    end else if (memop) begin
      if (dm_ack) wb_d.result = ex_wmem ? ex_alu_r : dm_rdata;
      else        bubble      = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      h_we    <= 1'b0;
      h_wreg  <= 1'b0;
      h_addr  <= '0;
      h_wdata <= '0;
      h_rd    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (!in_wait && memop) begin
        h_we    <= ex_wmem;
        h_wreg  <= ex_wreg;
        h_addr  <= ex_alu_r;
        h_wdata <= ex_wr_data;
        h_rd    <= ex_rd;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mem_err <= 1'b0;
    else     mem_err <= timeout_hit;
  end

  mem_wb_reg u_mem_wb (
    .clk    (clk),
    .rst    (rst),
    .bubble (bubble),
    .d      (wb_d),
    .q      (wb_q)
  );

  assign wb_result = wb_q.result;
  assign wb_wreg   = wb_q.wreg;
  assign wb_rd     = wb_q.rd;

endmodule
